core_run_sequencer: RTL
=======================

# core_run_sequencer

Batch sequencer for the 9-bit single-cycle core. On a `start` pulse it runs up to `NUM_PROGS` programs back to back. For each program it:

- drives `prog_sel`,
- holds the core in reset for a fixed number of cycles,
- pulses the core's `start`,
- counts execution cycles until the core raises `done`.

A per-program cycle budget bounds each run, and the block reports batch completion, timeout and run statistics. It sits between the testbench/top wrapper and the core's `clk`/`reset`/`start`/`done` pins.

## Interface
Parameters:
- `NUM_PROGS`, default 3 — programs per batch; legal range 1..15.
- `RST_CYCLES`, default 2 — core reset hold cycles per program; must be ≥1.
- `MAX_CYCLES`, default 4096 — RUN-cycle budget per program.
- `CNT_W`, default 16 — cycle counter width; must be ≥ clog2(MAX_CYCLES+1).

Ports:
- `clk`  in  1  — single clock.
- `reset`  in  1  — synchronous, active-high.
- `start`  in  1  — batch start request; sampled only in IDLE or FINISH.
- `core_done`  in  1  — the core's registered `done`.
- `core_reset`  out  1  — drives the core's `reset`.
- `core_start`  out  1  — drives the core's `start`; one-cycle pulse.
- `prog_sel`  out  4  — index of the program image selected for the core.
- `busy`  out  1  — high in HOLD, LAUNCH, RUN and NEXT.
- `done`  out  1  — batch complete; level.
- `timeout`  out  1  — batch aborted on budget; sticky until the next start.
- `cycle_count`  out  CNT_W  — RUN cycles of the most recently finished program.
- `run_count`  out  4  — programs completed normally in the current/last batch.

## Operation
- FSM states: IDLE, HOLD, LAUNCH, RUN, NEXT, FINISH.
- IDLE:
  - `core_reset`=1, `busy`=0.
  - `start`=1 → HOLD; clear `prog_sel`, `run_count`, `timeout`, `done`; load the hold counter.
- HOLD:
  - `core_reset`=1 for exactly RST_CYCLES cycles, then → LAUNCH.
- LAUNCH (1 cycle):
  - `core_reset`=0, `core_start`=1.
  - Clear the cycle counter.
  - `core_done` is ignored.
  - → RUN.
- RUN:
  - `core_reset`=0, `core_start`=0.
  - If `core_done`=1: latch the counter into `cycle_count`, increment `run_count`, → NEXT.
  - Else if counter == MAX_CYCLES-1: `cycle_count`=MAX_CYCLES, `timeout`=1, → FINISH. The rest of the batch is abandoned.
  - Else increment the counter.
- NEXT (1 cycle):
  - `core_reset`=1.
  - If `prog_sel`==NUM_PROGS-1 → FINISH.
  - Else increment `prog_sel` and reload the hold counter → HOLD.
- FINISH:
  - `done`=1, `core_reset`=1, `busy`=0.
  - `prog_sel`, `cycle_count`, `run_count` and `timeout` hold their values.
  - `start`=1 → HOLD with the same clearing as in IDLE.
- `start` while `busy`=1 is ignored, with no queuing.
- Simultaneous `core_done` and budget expiry: completion wins; no timeout.
- Counter arithmetic is unsigned. The counter never wraps, because the budget is checked before increment.

## Timing
- Reset values (synchronous, applied at the clock edge while `reset`=1):
  - state IDLE, `core_reset`=1, `core_start`=0, `prog_sel`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_count`=0, `run_count`=0.
- Reset asserted in any state, including mid-RUN, returns to IDLE on the next edge.
- All outputs are registered or decoded from state; none depend combinationally on inputs.
- Per-program schedule, with `start` sampled at edge t:
  - HOLD covers cycles t+1 .. t+RST_CYCLES.
  - LAUNCH is at t+RST_CYCLES+1.
  - RUN begins at t+RST_CYCLES+2.
- `cycle_count` = number of RUN cycles before the one where `core_done` is seen. A done on the first RUN cycle gives 0.
- Gap between programs: NEXT (1) + HOLD (RST_CYCLES) + LAUNCH (1).
- `done` rises one cycle after the final NEXT, or one cycle after the timeout cycle.

## Test plan
- Reset: `reset`=1 for 3 cycles, mid-batch → every output at its reset value and `core_reset`=1 on the following cycle.
- NUM_PROGS=1, RST_CYCLES=2, `start` at cycle 0, core model raises `core_done` on the 11th RUN cycle → `core_reset` high cycles 1–2, `core_start` high only at cycle 3, `cycle_count`=10, `run_count`=1, `done`=1, `timeout`=0.
- NUM_PROGS=3, done after 5/7/9 RUN cycles → `prog_sel` steps 0→1→2, each program preceded by a 2-cycle reset hold, final `cycle_count`=9, `run_count`=3, `done`=1.
- MAX_CYCLES=16, `core_done` held 0 on program 1 of 3 → after 16 RUN cycles: `timeout`=1, `cycle_count`=16, `run_count`=1, `prog_sel`=1, `done`=1, no further `core_start`.
- `core_done` rises exactly on the budget cycle → normal completion, `timeout`=0, `cycle_count`=15; `start` pulses during RUN → ignored.
- Restart from FINISH: `start` with `timeout`=1 → `timeout`, `done`, `run_count` cleared and `prog_sel`=0 on the next cycle.

Source files
------------

// File: rtl/core_run_sequencer.sv
// core_run_sequencer
//   Runs a batch of NUM_PROGS programs on the single-cycle core. For each
//   program it selects the image, holds the core in reset for RST_CYCLES
//   cycles, pulses the core start, then counts RUN cycles until core_done.
//   A RUN-cycle budget of MAX_CYCLES per program aborts the whole batch.
//
// Ports
//   clk, reset   : single clock, synchronous active-high reset
//   start        : batch start request, honoured only in IDLE or FINISH
//   core_done    : registered done from the core
//   core_reset   : reset to the core (high outside LAUNCH/RUN)
//   core_start   : one-cycle start pulse to the core
//   prog_sel     : program image index
//   busy         : batch in progress (HOLD, LAUNCH, RUN, NEXT)
//   done         : batch finished (level, FINISH state)
//   timeout      : batch aborted on budget, sticky until next start
//   cycle_count  : RUN cycles of the most recently finished program
//   run_count    : programs completed normally in this batch
module core_run_sequencer #(
  parameter int NUM_PROGS  = 3,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 4096,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             core_done,
  output logic             core_reset,
  output logic             core_start,
  output logic [3:0]       prog_sel,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [3:0]       run_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_BUDGET = CNT_W'(MAX_CYCLES);
  localparam logic [3:0]        LAST_PROG  = 4'(NUM_PROGS - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        prog_q, prog_d;
  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [3:0]        run_cnt_q, run_cnt_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    prog_d    = prog_q;
    cyc_cnt_d = cyc_cnt_q;
    run_cnt_d = run_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_FINISH: begin
        // cycle_count intentionally survives a restart
        if (start) begin
          state_d   = S_HOLD;
          prog_d    = 4'd0;
          run_cnt_d = 4'd0;
          timeout_d = 1'b0;
          hold_d    = HOLD_LOAD;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d = S_LAUNCH;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // completion is tested first so done on the budget cycle still counts
        if (core_done) begin
          cyc_cnt_d = cnt_q;
          run_cnt_d = run_cnt_q + 4'd1;
          state_d   = S_NEXT;
        end else if (cnt_q == CNT_LAST) begin
          cyc_cnt_d = CNT_BUDGET;
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (prog_q == LAST_PROG) begin
          state_d = S_FINISH;
        end else begin
          prog_d  = prog_q + 4'd1;
          hold_d  = HOLD_LOAD;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      hold_q    <= '0;
      cnt_q     <= '0;
      prog_q    <= 4'd0;
      cyc_cnt_q <= '0;
      run_cnt_q <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      prog_q    <= prog_d;
      cyc_cnt_q <= cyc_cnt_d;
      run_cnt_q <= run_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Control outputs are pure state decodes, so they never see inputs.
  always_comb begin
    core_reset = 1'b1;
    core_start = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_HOLD:   busy = 1'b1;
      S_LAUNCH: begin
        core_reset = 1'b0;
        core_start = 1'b1;
        busy       = 1'b1;
      end
      S_RUN: begin
        core_reset = 1'b0;
        busy       = 1'b1;
      end
      S_NEXT:   busy = 1'b1;
      S_FINISH: done = 1'b1;
      default:  ;
    endcase
  end

  assign prog_sel    = prog_q;
  assign timeout     = timeout_q;
  assign cycle_count = cyc_cnt_q;
  assign run_count   = run_cnt_q;

endmodule
